// File: rtl/clk_period_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_meter_if
// Description : Result/handshake bundle of clk_period_meter. The meter drives
//               the measurement results and status flags; the consumer drives
//               meas_ack.
//   meas_valid  result registers hold an unconsumed measurement
//   meas_ack    consumer accepts the current result
//   period_cyc  clock_in cycles between two consecutive rising edges
//   high_cyc    cycles the synchronized input was high in that period
//   timeout     sticky: no rising edge seen for TIMEOUT cycles
//   overrun     sticky: an unacknowledged result was overwritten
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_period_meter_if #(
    parameter int CNT_W = 28
);
    logic             meas_valid;
    logic             meas_ack;
    logic [CNT_W-1:0] period_cyc;
    logic [CNT_W-1:0] high_cyc;
    logic             timeout;
    logic             overrun;

    modport master (
        output meas_valid,
        output period_cyc,
        output high_cyc,
        output timeout,
        output overrun,
        input  meas_ack
    );

    modport slave (
        input  meas_valid,
        input  period_cyc,
        input  high_cyc,
        input  timeout,
        input  overrun,
        output meas_ack
    );
endinterface
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_meter
// Description : Measures the period and high time of a slow square wave that
//               is asynchronous to clock_in, in clock_in cycles, and hands
//               each result over through a valid/ack handshake.
//   clock_in  in   system clock, all logic on posedge
//   reset_n   in   asynchronous active-low reset (release is synchronized)
//   sig_in    in   measured signal, asynchronous to clock_in
//   meas      if   clk_period_meter_if.master: results, flags, meas_ack
// Revision    : 1.0 - initial release
// ============================================================================
module clk_period_meter #(
    parameter int               CNT_W   = 28,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(200000000)
) (
    input  wire logic           clock_in,
    input  wire logic           reset_n,
    input  wire logic           sig_in,
    clk_period_meter_if.master  meas
);

    localparam logic [0:0]       S_IDLE    = 1'b0;
    localparam logic [0:0]       S_MEAS    = 1'b1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // Reset: asserts asynchronously, releases on a clock edge so that no
    // flop sees a release too close to clock_in.
    logic r_rst_meta;
    logic r_rst_sync;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    logic             r_s1;
    logic             r_s2;
    logic             r_prev;
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_timeout;
    logic             r_overrun;

    logic w_rise;
    logic w_arm;
    logic w_capture;
    logic w_tmo;
    logic w_count;

    // Two-stage synchronizer, plus one more stage for edge detection.
    always_ff @(posedge clock_in or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= sig_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_prev;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock_in or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_rise) w_state_nxt = S_MEAS;
            S_MEAS:  if (!w_rise && (r_pcnt == TIMEOUT)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: control outputs ----------------
    // A rise in IDLE only arms the counters; a rise in MEAS closes a period.
    always_comb begin
        w_arm     = 1'b0;
        w_capture = 1'b0;
        w_tmo     = 1'b0;
        w_count   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_arm = w_rise;
            end
            S_MEAS: begin
                w_capture = w_rise;
                w_tmo     = !w_rise && (r_pcnt == TIMEOUT);
                w_count   = !w_rise && (r_pcnt != TIMEOUT);
            end
            default: begin
                w_arm = 1'b0;
            end
        endcase
    end

    // Period / high-time counters. They restart at 1 because the rise cycle
    // itself belongs to the new period and is a high cycle. Both saturate.
    always_ff @(posedge clock_in or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_pcnt <= '0;
            r_hcnt <= '0;
        end else if (w_arm || w_capture) begin
            r_pcnt <= c_cnt_one;
            r_hcnt <= c_cnt_one;
        end else if (w_count) begin
            if (r_pcnt != c_cnt_max) begin
                r_pcnt <= r_pcnt + c_cnt_one;
            end
            if (r_s2 && (r_hcnt != c_cnt_max)) begin
                r_hcnt <= r_hcnt + c_cnt_one;
            end
        end
    end

    // Result registers and handshake. A capture coinciding with an ack hands
    // the old result over and loads the new one, so it is not an overrun.
    always_ff @(posedge clock_in or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_capture) begin
            r_period  <= r_pcnt;
            r_high    <= r_hcnt;
            r_valid   <= 1'b1;
            r_timeout <= 1'b0;
            if (r_valid) begin
                r_overrun <= ~meas.meas_ack;
            end
        end else begin
            if (w_tmo) begin
                r_timeout <= 1'b1;
            end
            if (r_valid && meas.meas_ack) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign meas.meas_valid = r_valid;
    assign meas.period_cyc = r_period;
    assign meas.high_cyc   = r_high;
    assign meas.timeout    = r_timeout;
    assign meas.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_period_meter
// Description : Self-checking bench for clk_period_meter. Clock-synchronous
//               square waves are driven from a table; every closed period
//               pushes its expected result into a scoreboard that is popped
//               whenever meas_valid is seen. Hand-written sequences cover
//               reset, timeout, overrun and ack-on-capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

    localparam int CNT_W = 28;

    logic clock_in = 1'b0;
    logic reset_n  = 1'b1;
    logic sig_in   = 1'b0;

    clk_period_meter_if #(.CNT_W(CNT_W)) meas_if();

    clk_period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (28'd50)
    ) dut (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .sig_in   (sig_in),
        .meas     (meas_if)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int h;
        int l;
        int n;
        int exp_p;
        int exp_h;
    } vec_t;

    typedef struct {
        int p;
        int hi;
        int due;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[6];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    bit   auto_chk = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, then return so
    // the caller can drive inputs for the next cycle.
    task automatic step();
        exp_t e;
        @(posedge clock_in);
        #1;
        cyc++;
        if (auto_chk && meas_if.meas_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got meas_valid=1, required no result (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("period_cyc", int'(meas_if.period_cyc), e.p);
                chk("high_cyc", int'(meas_if.high_cyc), e.hi);
                chk("valid_cycle", cyc, e.due);
                chk("timeout_on_result", int'(meas_if.timeout), 0);
                chk("overrun_on_result", int'(meas_if.overrun), 0);
            end
        end
    endtask

    // n periods of h high / l low cycles; each rise except an arming one
    // closes a period and is due 3 clocks later.
    task automatic drive_wave(input int h, input int l, input int n, input bit arms,
                              input int ep, input int eh);
        exp_t e;
        for (int p = 0; p < n; p++) begin
            sig_in = 1'b1;
            if (!(arms && p == 0)) begin
                e.p   = ep;
                e.hi  = eh;
                e.due = cyc + 3;
                sb.push_back(e);
            end
            repeat (h) step();
            sig_in = 1'b0;
            repeat (l) step();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"},   int'(meas_if.meas_valid), 0);
        chk({tag, "_period"},  int'(meas_if.period_cyc), 0);
        chk({tag, "_high"},    int'(meas_if.high_cyc), 0);
        chk({tag, "_timeout"}, int'(meas_if.timeout), 0);
        chk({tag, "_overrun"}, int'(meas_if.overrun), 0);
    endtask

    task automatic do_reset();
        sig_in  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_zero("rst_async");
        repeat (2) step();
        reset_n = 1'b1;
        repeat (4) step();
        chk_zero("rst_after");
    endtask

    task automatic drain_and_check();
        repeat (4) step();
        chk("scoreboard_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish within budget");
        $fatal(1);
    end

    initial begin
        int c0;
        tbl[0] = '{5, 5, 4, 10, 5};
        tbl[1] = '{3, 4, 4, 7, 3};
        tbl[2] = '{1, 1, 5, 2, 1};
        tbl[3] = '{1, 8, 3, 9, 1};
        tbl[4] = '{20, 20, 2, 40, 20};
        tbl[5] = '{6, 2, 3, 8, 6};

        meas_if.meas_ack = 1'b0;
        repeat (2) step();
        do_reset();

        // Table: ack held high so every capture shows as a one-cycle valid.
        auto_chk         = 1'b1;
        meas_if.meas_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_reset();
            drive_wave(tbl[i].h, tbl[i].l, tbl[i].n, 1'b1, tbl[i].exp_p, tbl[i].exp_h);
            drain_and_check();
        end

        // Reset in the middle of a measurement with a pending result.
        auto_chk         = 1'b0;
        meas_if.meas_ack = 1'b0;
        do_reset();
        drive_wave(5, 5, 2, 1'b1, 10, 5);
        sig_in = 1'b1;
        repeat (3) step();
        sb.delete();
        chk("pre_reset_valid", int'(meas_if.meas_valid), 1);
        do_reset();
        auto_chk         = 1'b1;
        meas_if.meas_ack = 1'b1;
        drive_wave(5, 5, 2, 1'b1, 10, 5);
        drain_and_check();

        // Timeout: one rise then silence.
        do_reset();
        sig_in = 1'b1;
        c0     = cyc;
        step();
        sig_in = 1'b0;
        while (cyc < c0 + 52) step();
        chk("timeout_before_limit", int'(meas_if.timeout), 0);
        step();
        chk("timeout_at_limit", int'(meas_if.timeout), 1);
        chk("timeout_no_result", int'(meas_if.meas_valid), 0);
        drive_wave(5, 5, 1, 1'b1, 10, 5);
        chk("timeout_held_after_rearm", int'(meas_if.timeout), 1);
        drive_wave(5, 5, 2, 1'b0, 10, 5);
        drain_and_check();

        // Overrun: two captures without ack, then a single ack pulse.
        auto_chk         = 1'b0;
        meas_if.meas_ack = 1'b0;
        do_reset();
        drive_wave(5, 5, 1, 1'b1, 10, 5);
        drive_wave(4, 4, 2, 1'b0, 8, 4);
        sb.delete();
        chk("ovr_valid", int'(meas_if.meas_valid), 1);
        chk("ovr_flag", int'(meas_if.overrun), 1);
        chk("ovr_period", int'(meas_if.period_cyc), 8);
        chk("ovr_high", int'(meas_if.high_cyc), 4);
        meas_if.meas_ack = 1'b1;
        step();
        meas_if.meas_ack = 1'b0;
        chk("ack_valid_clr", int'(meas_if.meas_valid), 0);
        chk("ack_overrun_clr", int'(meas_if.overrun), 0);
        step();
        meas_if.meas_ack = 1'b1;
        step();
        meas_if.meas_ack = 1'b0;
        chk("idle_ack_ignored", int'(meas_if.meas_valid), 0);

        // Ack on the capture edge while an overrun is flagged.
        do_reset();
        drive_wave(5, 5, 1, 1'b1, 10, 5);
        drive_wave(3, 3, 1, 1'b0, 10, 5);
        drive_wave(4, 4, 1, 1'b0, 6, 3);
        sb.delete();
        chk("pre_ackcap_overrun", int'(meas_if.overrun), 1);
        chk("pre_ackcap_period", int'(meas_if.period_cyc), 6);
        chk("pre_ackcap_high", int'(meas_if.high_cyc), 3);
        sig_in = 1'b1;
        step();
        step();
        meas_if.meas_ack = 1'b1;
        step();
        meas_if.meas_ack = 1'b0;
        chk("ackcap_valid", int'(meas_if.meas_valid), 1);
        chk("ackcap_period", int'(meas_if.period_cyc), 8);
        chk("ackcap_high", int'(meas_if.high_cyc), 4);
        chk("ackcap_overrun", int'(meas_if.overrun), 0);
        step();
        sig_in = 1'b0;
        meas_if.meas_ack = 1'b1;
        step();
        meas_if.meas_ack = 1'b0;
        chk("ackcap_final_clr", int'(meas_if.meas_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
